snes_wr_capture: RTL and testbench

SNES B-bus write-port receiver for the 40 MHz CPLD/FPGA clock domain. It detects SNES CPU writes (PAWR_n strobes) to the data port $21FC and control port $21FD and queues data-port bytes in a 16-entry FIFO. A host-side valid/ready stream drains the FIFO, and a status byte is returned on reads of $21FE. It is the SNES-to-host counterpart of the boot-ROM read responder and sits beside it under the same top level, which owns the tri-state data pins.

---
 rtl/snes_wr_capture_pkg.sv | 34 +++
 rtl/snes_rx_fifo.sv | 67 ++++++
 rtl/snes_wr_capture.sv | 128 ++++++++++++
 tb/tb_snes_wr_capture.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_wr_capture_pkg.sv
// Shared SNES B-bus definitions for the write-capture receiver and boot-ROM responder.
// Latency: none (constants, types and a combinational helper only).
// Backpressure: not applicable.
`timescale 1ns/1ps
package snes_wr_capture_pkg;

  // B-bus low address bytes of the $21FC/$21FD/$21FE ports
  localparam logic [7:0] BBUS_PORT_DATA = 8'hFC;
  localparam logic [7:0] BBUS_PORT_CTRL = 8'hFD;
  localparam logic [7:0] BBUS_PORT_STAT = 8'hFE;

  // Control port bit positions
  localparam int CTRL_FLUSH_BIT    = 0;
  localparam int CTRL_DOORBELL_BIT = 1;

  // Status port bit position of the sticky overflow flag
  localparam int STAT_OVF_BIT = 7;

  // One captured B-bus write cycle
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } bus_cap_t;

  // Status byte: overflow in the top bit, FIFO fill level in the low five bits
  function automatic logic [7:0] status_byte(input logic ovf, input logic [4:0] cnt);
    logic [7:0] s;
    s               = '0;
    s[4:0]          = cnt;
    s[STAT_OVF_BIT] = ovf;
    return s;
  endfunction

endpackage

// File: rtl/snes_rx_fifo.sv
// Synchronous show-ahead FIFO with push, pop, flush, fill count and full flag.
// Latency: push visible at the read port the cycle after the write edge; head is combinational.
// Backpressure: push is refused when full unless a pop happens in the same cycle; flush beats pop.
`timescale 1ns/1ps
module snes_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];

  // Storage array, written at the push edge; no reset needed since reads are gated by count
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and fill count; flush returns everything to the empty state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/snes_wr_capture.sv
// SNES B-bus write-port receiver: filters PAWR_n strobes, queues data-port bytes, decodes control, serves status.
// Latency: PAWR_n rise commits 3-4 clk edges later; m_valid and doorbell follow the commit by one cycle.
// Backpressure: host drains via m_valid/m_ready; a data write arriving at a full FIFO is dropped and sets overflow.
`timescale 1ns/1ps
module snes_wr_capture
  import snes_wr_capture_pkg::*;
#(
  parameter logic [7:0] PORT_DATA  = BBUS_PORT_DATA,
  parameter logic [7:0] PORT_CTRL  = BBUS_PORT_CTRL,
  parameter logic [7:0] PORT_STAT  = BBUS_PORT_STAT,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic       PAWR_n,
  input  logic       PARD_n,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       doorbell,
  output logic       overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]    pawr_sync;
  logic          pawr_s;
  logic          pawr_d;
  logic [7:0]    addr_sync1, addr_sync2;
  logic [7:0]    data_sync1, data_sync2;
  bus_cap_t      cap;
  logic          armed;
  logic          commit;
  logic          hit_data;
  logic          hit_ctrl;
  logic          do_flush;
  logic          do_ring;
  logic          pop;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  // Strobe synchronizer; the third stage gives a delayed copy for edge and level detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pawr_sync <= 3'b111;
    else        pawr_sync <= {pawr_sync[1:0], PAWR_n};
  end

  assign pawr_s = pawr_sync[1];
  assign pawr_d = pawr_sync[2];

  // Address and data bus synchronizers, aligned with the strobe's second stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_sync1 <= 8'hFF;
      addr_sync2 <= 8'hFF;
      data_sync1 <= 8'hFF;
      data_sync2 <= 8'hFF;
    end else begin
      addr_sync1 <= addr;
      addr_sync2 <= addr_sync1;
      data_sync1 <= data_in;
      data_sync2 <= data_sync1;
    end
  end

  // Track the bus while the strobe has been low for two samples; a shorter pulse never arms a commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap   <= '0;
      armed <= 1'b0;
    end else if (!pawr_s && !pawr_d) begin
      cap   <= '{addr: addr_sync2, data: data_sync2};
      armed <= 1'b1;
    end else if (pawr_s && !pawr_d) begin
      armed <= 1'b0;
    end
  end

  assign commit   = pawr_s & ~pawr_d & armed;
  assign hit_data = commit & (cap.addr == PORT_DATA);
  assign hit_ctrl = commit & (cap.addr == PORT_CTRL);
  assign do_flush = hit_ctrl & cap.data[CTRL_FLUSH_BIT];
  assign do_ring  = hit_ctrl & cap.data[CTRL_DOORBELL_BIT];
  assign pop      = m_valid & m_ready;

  snes_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (hit_data),
    .push_data (cap.data),
    .pop       (pop),
    .flush     (do_flush),
    .rd_data   (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_valid = ~fifo_empty;
  assign m_data  = m_valid ? fifo_head : 8'h00;

  // Doorbell pulse one cycle after a control commit; flush on the same write still clears the FIFO first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) doorbell <= 1'b0;
    else        doorbell <= do_ring;
  end

  // Sticky overflow: set when a data byte is refused, cleared only by flush or reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            overflow <= 1'b0;
    else if (do_flush)                     overflow <= 1'b0;
    else if (hit_data && fifo_full && !pop) overflow <= 1'b1;
  end

  // Status read decode works on raw pins so the byte is on the bus within the SNES read window
  assign data_oe  = ~PARD_n & (addr == PORT_STAT);
  assign data_out = data_oe ? status_byte(overflow, 5'(fifo_count)) : 8'h00;

endmodule

// File: tb/tb_snes_wr_capture.sv
`timescale 1ns/1ps
module tb_snes_wr_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic       PAWR_n;
  logic       PARD_n;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       doorbell;
  logic       overflow;

  snes_wr_capture dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .PAWR_n   (PAWR_n),
    .PARD_n   (PARD_n),
    .data_out (data_out),
    .data_oe  (data_oe),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .doorbell (doorbell),
    .overflow (overflow)
  );

  always #12.5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Reference model: FIFO contents as a plain queue plus the sticky overflow flag
  logic [7:0] exp_q [$];
  bit         ovf_m;
  logic [7:0] mon_exp;

  int lat;
  int db_cnt;
  int db_step;

  task automatic check(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: a handshake seen mid-cycle completes at the next rising edge
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL pop_unexpected: got data 0x%0h, expected no pop", m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_data", int'(m_data), int'(mon_exp));
      end
    end
  end

  // One SNES write cycle; strobe low 4 clk, then 11 clk of bus idle before returning
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input bit ready_at_commit);
    bit accept;
    bit was_ready;
    bit exp_db;
    accept    = 1'b0;
    was_ready = 1'b0;
    addr    = a;
    data_in = d;
    PAWR_n  = 1'b0;
    repeat (4) step();
    PAWR_n  = 1'b1;
    lat     = -1;
    db_cnt  = 0;
    db_step = -1;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 2) begin
        was_ready = m_ready;
        if (ready_at_commit) m_ready = 1'b1;
        accept = (exp_q.size() < 16) || (m_ready && exp_q.size() > 0);
      end
      if (k == 3) begin
        if (ready_at_commit) m_ready = was_ready;
        if (a == 8'hFC) begin
          if (accept) exp_q.push_back(d);
          else        ovf_m = 1'b1;
        end else if (a == 8'hFD && d[0]) begin
          exp_q.delete();
          ovf_m = 1'b0;
        end
      end
      if (lat < 0 && m_valid) lat = k;
      if (doorbell) begin
        db_cnt++;
        if (db_step < 0) db_step = k;
      end
    end
    exp_db = (a == 8'hFD) && d[1];
    check("doorbell_pulses", db_cnt, exp_db ? 1 : 0);
    if (exp_db) check("doorbell_timing", db_step, 3);
  endtask

  // Status read; only meaningful while m_ready is held low
  task automatic status_check(input string name);
    logic [7:0] e;
    e      = {ovf_m, 2'b00, 5'(exp_q.size())};
    addr   = 8'hFE;
    PARD_n = 1'b0;
    #3;
    check({name, "_oe"}, int'(data_oe), 1);
    check(name, int'(data_out), int'(e));
    PARD_n = 1'b1;
    addr   = 8'h00;
    step();
  endtask

  task automatic wait_drain(input string name);
    m_ready = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || m_valid); i++) step();
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_valid"}, int'(m_valid), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    addr    = 8'h00;
    data_in = 8'h00;
    PAWR_n  = 1'b1;
    PARD_n  = 1'b1;
    m_ready = 1'b0;
    ovf_m   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_m_valid",  int'(m_valid),  0);
    check("rst_m_data",   int'(m_data),   0);
    check("rst_doorbell", int'(doorbell), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_data_oe",  int'(data_oe),  0);
    rst_n = 1'b1;
    step();
    status_check("stat_reset");

    // In-order delivery and strobe-to-valid latency
    m_ready = 1'b1;
    bus_write(8'hFC, 8'h5A, 1'b0);
    check("mvalid_latency_in_3_to_5", int'(lat >= 3 && lat <= 5), 1);
    bus_write(8'hFC, 8'hA5, 1'b0);
    bus_write(8'hFC, 8'h3C, 1'b0);
    wait_drain("drain_basic");

    // Overflow: 17 bytes into 16 entries
    m_ready = 1'b0;
    for (int i = 0; i <= 16; i++) bus_write(8'hFC, 8'(i), 1'b0);
    status_check("stat_full_ovf");
    check("ovf_pin", int'(overflow), 1);
    wait_drain("drain_ovf");
    m_ready = 1'b0;
    status_check("stat_ovf_sticky");

    // Flush with 5 bytes held
    for (int i = 0; i < 5; i++) bus_write(8'hFC, 8'(8'h20 + i), 1'b0);
    bus_write(8'hFD, 8'h01, 1'b0);
    check("flush_m_valid", int'(m_valid), 0);
    check("flush_overflow", int'(overflow), 0);
    status_check("stat_flush");

    // Doorbell only, then flush plus doorbell
    bus_write(8'hFC, 8'h11, 1'b0);
    bus_write(8'hFC, 8'h22, 1'b0);
    bus_write(8'hFD, 8'h02, 1'b0);
    status_check("stat_doorbell_keeps");
    bus_write(8'hFD, 8'h03, 1'b0);
    check("flush_ring_m_valid", int'(m_valid), 0);
    status_check("stat_flush_ring");

    // One-cycle glitch and neighbouring addresses
    addr    = 8'hFC;
    data_in = 8'h77;
    PAWR_n  = 1'b0;
    step();
    PAWR_n  = 1'b1;
    repeat (12) step();
    check("glitch_m_valid", int'(m_valid), 0);
    status_check("stat_glitch");
    bus_write(8'hFB, 8'h11, 1'b0);
    bus_write(8'hFF, 8'h22, 1'b0);
    check("neighbour_m_valid", int'(m_valid), 0);
    status_check("stat_neighbour");

    // Full FIFO with a pop in the commit cycle
    for (int i = 0; i < 16; i++) bus_write(8'hFC, 8'(8'h40 + i), 1'b0);
    bus_write(8'hFC, 8'hEE, 1'b1);
    status_check("stat_full_pushpop");
    check("full_pushpop_ovf", int'(overflow), 0);
    wait_drain("drain_pushpop");

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      int r;
      r       = $urandom_range(0, 9);
      m_ready = ($urandom_range(0, 2) == 0);
      if (r < 7) begin
        bus_write(8'hFC, 8'($urandom()), 1'b0);
      end else if (r == 7) begin
        bus_write(8'hFD, 8'($urandom()), 1'b0);
      end else if (r == 8) begin
        case ($urandom_range(0, 3))
          0:       bus_write(8'hFB, 8'($urandom()), 1'b0);
          1:       bus_write(8'hFF, 8'($urandom()), 1'b0);
          2:       bus_write(8'hFE, 8'($urandom()), 1'b0);
          default: bus_write(8'h00, 8'($urandom()), 1'b0);
        endcase
      end else begin
        m_ready = 1'b0;
        step();
        step();
        status_check("stat_random");
      end
    end
    m_ready = 1'b0;
    step();
    status_check("stat_random_end");
    wait_drain("drain_random");

    // Reset mid-stream, including an armed partial capture
    m_ready = 1'b0;
    bus_write(8'hFC, 8'h91, 1'b0);
    bus_write(8'hFC, 8'h92, 1'b0);
    addr    = 8'hFC;
    data_in = 8'h99;
    PAWR_n  = 1'b0;
    repeat (4) step();
    #5;
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid",  int'(m_valid),  0);
    check("midrst_m_data",   int'(m_data),   0);
    check("midrst_doorbell", int'(doorbell), 0);
    check("midrst_overflow", int'(overflow), 0);
    check("midrst_data_oe",  int'(data_oe),  0);
    exp_q.delete();
    ovf_m  = 1'b0;
    PAWR_n = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    repeat (12) step();
    check("postrst_m_valid", int'(m_valid), 0);
    status_check("stat_postrst");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
